// File: rtl/line_matrix_v2.sv
// rtl/line_matrix_v2.sv - routes synchronised input lines to outputs with per-output mode and pulse stretch
// Config lands in shadow registers and is copied to the active map in a single COMMIT cycle.
module line_matrix_v2 #(
  parameter int N_IN        = 8,
  parameter int N_OUT       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_W   = 8,
  localparam int IDX_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int SRC_W      = $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_IN-1:0]      in_lines,
  output logic [N_OUT-1:0]     out_lines,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [SRC_W-1:0]     cfg_src,
  input  logic [1:0]           cfg_mode,
  input  logic [STRETCH_W-1:0] cfg_stretch,
  input  logic                 cfg_we,
  input  logic                 cfg_commit,
  output logic                 cfg_err
);
  localparam int SRC_N = 1 << SRC_W;

  typedef enum logic {IDLE, COMMIT} state_t;
  state_t state;

  logic [1:0]           sh_mode    [N_OUT];
  logic [SRC_W-1:0]     sh_src     [N_OUT];
  logic [STRETCH_W-1:0] sh_stretch [N_OUT];
  logic [1:0]           act_mode    [N_OUT];
  logic [SRC_W-1:0]     act_src     [N_OUT];
  logic [STRETCH_W-1:0] act_stretch [N_OUT];
  logic [STRETCH_W-1:0] cnt         [N_OUT];

  logic [N_IN-1:0]  sync_q [SYNC_STAGES];
  logic [SRC_N-1:0] sync_pad;
  logic [N_OUT-1:0] mapped;
  logic [N_OUT-1:0] prev_mapped;
  logic             accept;
  logic             idx_ok;
  logic             src_ok;
  logic             wr_ok;

  assign accept = cfg_valid & cfg_ready;
  assign idx_ok = 32'(cfg_idx) < 32'(N_OUT);
  // off and force-high never look at the source, so any src is legal for them
  assign src_ok = (cfg_mode == 2'b00) || (cfg_mode == 2'b11) || (32'(cfg_src) < 32'(N_IN));
  assign wr_ok  = accept & cfg_we & idx_ok & src_ok;

  // Zero-padded so a non-power-of-two N_IN never indexes past the synchroniser
  assign sync_pad = SRC_N'(sync_q[SYNC_STAGES-1]);

  always_comb begin
    mapped = '0;
    for (int o = 0; o < N_OUT; o++) begin
      case (act_mode[o])
        2'b00:   mapped[o] = 1'b0;
        2'b01:   mapped[o] = sync_pad[act_src[o]];
        2'b10:   mapped[o] = ~sync_pad[act_src[o]];
        default: mapped[o] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      for (int o = 0; o < N_OUT; o++) begin
        sh_mode[o]     <= '0;
        sh_src[o]      <= '0;
        sh_stretch[o]  <= '0;
        act_mode[o]    <= '0;
        act_src[o]     <= '0;
        act_stretch[o] <= '0;
      end
    end else begin
      cfg_err <= accept & cfg_we & ~(idx_ok & src_ok);
      for (int o = 0; o < N_OUT; o++) begin
        if (wr_ok && cfg_idx == IDX_W'(o)) begin
          sh_mode[o]    <= cfg_mode;
          sh_src[o]     <= cfg_src;
          sh_stretch[o] <= cfg_stretch;
        end
      end
      case (state)
        IDLE: begin
          if (accept && cfg_commit) begin
            state     <= COMMIT;
            cfg_ready <= 1'b0;
          end
        end
        COMMIT: begin
          for (int o = 0; o < N_OUT; o++) begin
            act_mode[o]    <= sh_mode[o];
            act_src[o]     <= sh_src[o];
            act_stretch[o] <= sh_stretch[o];
          end
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_mapped <= '0;
      out_lines   <= '0;
      for (int o = 0; o < N_OUT; o++) cnt[o] <= '0;
    end else begin
      sync_q[0] <= in_lines;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int o = 0; o < N_OUT; o++) begin
        out_lines[o] <= mapped[o] | (cnt[o] != '0);
        // Clearing edge history on commit lets a new map start from a clean rising edge
        if (state == COMMIT) begin
          prev_mapped[o] <= 1'b0;
          cnt[o]         <= '0;
        end else begin
          prev_mapped[o] <= mapped[o];
          if (mapped[o] && !prev_mapped[o]) cnt[o] <= act_stretch[o];
          else if (cnt[o] != '0)            cnt[o] <= cnt[o] - STRETCH_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_line_matrix_v2.sv
// tb/tb_line_matrix_v2.sv - directed vector bench for line_matrix_v2 built with N_IN=6, N_OUT=10
module tb_line_matrix_v2;
  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] in_lines;
  logic [9:0] out_lines;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_idx;
  logic [2:0] cfg_src;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_stretch;
  logic       cfg_we;
  logic       cfg_commit;
  logic       cfg_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  line_matrix_v2 #(.N_IN(6), .N_OUT(10), .SYNC_STAGES(2), .STRETCH_W(8)) dut (
    .clk(clk), .rstn(rstn), .in_lines(in_lines), .out_lines(out_lines),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_src(cfg_src),
    .cfg_mode(cfg_mode), .cfg_stretch(cfg_stretch), .cfg_we(cfg_we),
    .cfg_commit(cfg_commit), .cfg_err(cfg_err)
  );

  typedef struct {
    logic       we;
    logic       commit;
    logic [3:0] idx;
    logic [2:0] src;
    logic [1:0] mode;
    logic [7:0] st;
    logic       err;
  } beat_t;

  typedef struct {
    logic [5:0] in;
    logic [9:0] out;
  } vec_t;

  beat_t beats [11];
  vec_t  vecs  [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic beat(input logic we, input logic commit, input logic [3:0] idx,
                      input logic [2:0] src, input logic [1:0] mode, input logic [7:0] st);
    cfg_valid   = 1'b1;
    cfg_we      = we;
    cfg_commit  = commit;
    cfg_idx     = idx;
    cfg_src     = src;
    cfg_mode    = mode;
    cfg_stretch = st;
    tick();
    cfg_valid  = 1'b0;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  // seq[i] drives in_lines[1] for slot i; bit i of the result is out_lines[2] after that slot's edge
  task automatic run_pulse(input string name, input logic [15:0] seq, input int n, input logic [15:0] exp);
    logic [15:0] got;
    got = '0;
    for (int i = 0; i < n; i++) begin
      in_lines[1] = seq[i];
      tick();
      got[i] = out_lines[2];
    end
    in_lines[1] = 1'b0;
    check(name, 32'(got), 32'(exp));
    repeat (8) tick();
  endtask

  initial begin
    beats[0]  = '{1'b1, 1'b0, 4'd0,  3'd3, 2'b01, 8'd0, 1'b0};
    beats[1]  = '{1'b1, 1'b0, 4'd1,  3'd0, 2'b10, 8'd0, 1'b0};
    beats[2]  = '{1'b1, 1'b0, 4'd2,  3'd5, 2'b01, 8'd0, 1'b0};
    beats[3]  = '{1'b1, 1'b0, 4'd3,  3'd7, 2'b11, 8'd0, 1'b0};
    beats[4]  = '{1'b1, 1'b0, 4'd4,  3'd6, 2'b00, 8'd0, 1'b0};
    beats[5]  = '{1'b1, 1'b0, 4'd10, 3'd0, 2'b11, 8'd0, 1'b1};
    beats[6]  = '{1'b1, 1'b0, 4'd15, 3'd1, 2'b01, 8'd0, 1'b1};
    beats[7]  = '{1'b1, 1'b0, 4'd6,  3'd6, 2'b01, 8'd0, 1'b1};
    beats[8]  = '{1'b1, 1'b0, 4'd6,  3'd7, 2'b10, 8'd0, 1'b1};
    beats[9]  = '{1'b0, 1'b0, 4'd12, 3'd7, 2'b10, 8'd0, 1'b0};
    beats[10] = '{1'b0, 1'b1, 4'd0,  3'd0, 2'b00, 8'd0, 1'b0};

    vecs[0] = '{6'b001000, 10'b0000001011};
    vecs[1] = '{6'b000000, 10'b0000001010};
    vecs[2] = '{6'b000001, 10'b0000001000};
    vecs[3] = '{6'b100001, 10'b0000001100};
    vecs[4] = '{6'b101001, 10'b0000001101};
    vecs[5] = '{6'b111110, 10'b0000001111};

    rstn = 1'b0; in_lines = '0; cfg_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    cfg_idx = '0; cfg_src = '0; cfg_mode = '0; cfg_stretch = '0;
    tick();
    tick();
    check("reset out_lines", 32'(out_lines), 32'h0);
    check("reset cfg_ready", 32'(cfg_ready), 32'h1);
    check("reset cfg_err",   32'(cfg_err),   32'h0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      beat(beats[i].we, beats[i].commit, beats[i].idx, beats[i].src, beats[i].mode, beats[i].st);
      check($sformatf("beat%0d cfg_err", i), 32'(cfg_err), 32'(beats[i].err));
      check($sformatf("beat%0d out_lines", i), 32'(out_lines), 32'h0);
    end
    tick();
    tick();
    check("map after commit", 32'(out_lines), 32'h00A);

    for (int i = 0; i < 6; i++) begin
      in_lines = vecs[i].in;
      tick();
      tick();
      check($sformatf("vec%0d before latency", i), 32'(out_lines),
            32'((i == 0) ? 10'h00A : vecs[i-1].out));
      tick();
      check($sformatf("vec%0d mapped", i), 32'(out_lines), 32'(vecs[i].out));
    end
    in_lines = '0;
    repeat (4) tick();

    beat(1'b1, 1'b1, 4'd2, 3'd1, 2'b10, 8'd4);
    repeat (10) tick();
    run_pulse("invert pulse", 16'h0001, 8, 16'h00FB);
    beat(1'b1, 1'b1, 4'd2, 3'd1, 2'b01, 8'd4);
    repeat (10) tick();
    run_pulse("stretch pulse",    16'h0001, 10, 16'h007C);
    run_pulse("stretch retrigger", 16'h0005, 12, 16'h01FC);
    run_pulse("stretch long level", 16'h007F, 12, 16'h01FC);

    beat(1'b1, 1'b0, 4'd5, 3'd0, 2'b11, 8'd0);
    check("force write err", 32'(cfg_err), 32'h0);
    repeat (3) tick();
    check("shadow only out5", 32'(out_lines[5]), 32'h0);
    beat(1'b0, 1'b1, 4'd0, 3'd0, 2'b00, 8'd0);
    check("commit ready low", 32'(cfg_ready), 32'h0);
    check("commit out5 early", 32'(out_lines[5]), 32'h0);
    tick();
    check("commit ready back", 32'(cfg_ready), 32'h1);
    check("commit out5 k+2", 32'(out_lines[5]), 32'h0);
    tick();
    check("commit out5 k+3", 32'(out_lines[5]), 32'h1);

    beat(1'b1, 1'b1, 4'd2, 3'd1, 2'b01, 8'd200);
    repeat (10) tick();
    in_lines[1] = 1'b1;
    tick();
    in_lines[1] = 1'b0;
    repeat (5) tick();
    check("stretch running", 32'(out_lines[2]), 32'h1);
    beat(1'b1, 1'b1, 4'd7, 3'd0, 2'b11, 8'd0);
    check("in commit ready", 32'(cfg_ready), 32'h0);
    #1 rstn = 1'b0;
    #1;
    check("async reset out_lines", 32'(out_lines), 32'h0);
    check("async reset cfg_ready", 32'(cfg_ready), 32'h1);
    in_lines = '1;
    #2 rstn = 1'b1;
    repeat (6) tick();
    check("post reset out_lines", 32'(out_lines), 32'h0);
    check("post reset cfg_ready", 32'(cfg_ready), 32'h1);
    check("post reset cfg_err",   32'(cfg_err),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
